// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one load/store per transaction over a 64-bit synchronous RAM.
// Sub-doubleword stores are read-modify-write. The pipeline is held via mem_stall until the single RESP cycle.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd8;

    function automatic logic [63:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] v);
        case (f3)
            3'b000:  load_ext = {{56{v[7]}}, v[7:0]};
            3'b001:  load_ext = {{48{v[15]}}, v[15:0]};
            3'b010:  load_ext = {{32{v[31]}}, v[31:0]};
            3'b011:  load_ext = v;
            3'b100:  load_ext = {56'd0, v[7:0]};
            3'b101:  load_ext = {48'd0, v[15:0]};
            3'b110:  load_ext = {32'd0, v[31:0]};
            default: load_ext = 64'd0;
        endcase
    endfunction

    logic [63:0]       mem [DEPTH_WORDS];
    logic [63:0]       rd_data_r;
    state_t            state_r;
    state_t            next_state_s;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [63:0]       resp_rdata_r;

    logic              req_present_s;
    logic              fault_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [5:0]        shift_s;
    logic [63:0]       merged_s;
    logic [63:0]       loaded_s;
    logic              stall_s;
    logic              ram_re_s;
    logic              ram_we_s;
    logic [63:0]       ram_wdata_s;
    logic              err_next_s;
    logic              rdata_load_s;
    logic [63:0]       rdata_next_s;

    assign req_present_s = req_re | req_we;
    assign word_idx_s    = req_addr[ADDR_W+2:3];
    assign shift_s       = {req_addr[2:0], 3'b000};

    // Request decode: fault classification and the lane merge / extract datapaths.
    always_comb begin
        fault_s  = req_present_s & (
                       (req_re & req_we)
                     | (req_func3 == 3'b111)
                     | ((req_func3[2:1] == 2'b11) & req_we)
                     | ((req_addr[2:0] & align_mask(req_func3[1:0])) != 3'b000)
                     | (req_addr >= BYTE_LIMIT));
        merged_s = (rd_data_r & ~(lane_mask(req_func3[1:0]) << shift_s))
                 | ((req_wdata & lane_mask(req_func3[1:0])) << shift_s);
        loaded_s = load_ext(req_func3, rd_data_r >> shift_s);
    end

    // Next-state, RAM control and response staging.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        ram_re_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_wdata_s  = 64'd0;
        err_next_s   = 1'b0;
        rdata_load_s = 1'b0;
        rdata_next_s = resp_rdata_r;
        case (state_r)
            IDLE: begin
                stall_s = req_present_s;
                if (!req_present_s) begin
                    next_state_s = IDLE;
                end else if (fault_s) begin
                    next_state_s = RESP;
                    err_next_s   = 1'b1;
                    rdata_load_s = 1'b1;
                    rdata_next_s = 64'd0;
                end else if (req_we && (req_func3[1:0] == 2'b11)) begin
                    ram_we_s     = 1'b1;
                    ram_wdata_s  = req_wdata;
                    next_state_s = RESP;
                end else begin
                    ram_re_s     = 1'b1;
                    next_state_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall_s      = 1'b1;
                next_state_s = RESP;
                if (req_we) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = merged_s;
                end else begin
                    rdata_load_s = 1'b1;
                    rdata_next_s = loaded_s;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'd0;
        end else begin
            state_r      <= next_state_s;
            resp_valid_r <= (next_state_s == RESP);
            resp_err_r   <= err_next_s;
            if (rdata_load_s) begin
                resp_rdata_r <= rdata_next_s;
            end
        end
    end

    // RAM array; a write on a reset edge is dropped so no partial update lands.
    always_ff @(posedge clk) begin
        if (ram_we_s && resetn) begin
            mem[word_idx_s] <= ram_wdata_s;
        end
        if (ram_re_s) begin
            rd_data_r <= mem[word_idx_s];
        end
    end

    assign mem_stall  = stall_s & resetn;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed load/store results, latencies, faults and reset cases.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_re = 1'b0;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [2:0]  req_func3 = 3'd0;
    logic        mem_stall;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .mem_stall  (mem_stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request just after a rising edge, wait for RESP, then drop it.
    task automatic xact(input string tag, input logic re, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] f3, input logic chk_data,
                        input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        int          lat = 0;
        int          stl = 0;
        logic        seen = 1'b0;
        logic        got_err = 1'b0;
        logic [63:0] got_data = 64'd0;
        req_re    = re;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_func3 = f3;
        for (int n = 0; n < 8; n++) begin
            if (!seen) begin
                @(negedge clk);
                if (mem_stall) stl++;
                if (resp_valid) begin
                    seen     = 1'b1;
                    got_data = resp_rdata;
                    got_err  = resp_err;
                end else begin
                    lat++;
                end
            end
        end
        check_eq({tag, "_done"}, 64'(seen), 64'd1);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_stall"}, 64'(stl), 64'(exp_lat));
        check_eq({tag, "_err"}, 64'(got_err), 64'(exp_err));
        if (chk_data) check_eq({tag, "_data"}, got_data, exp_data);
        @(posedge clk);
        #1;
        req_re = 1'b0;
        req_we = 1'b0;
    endtask

    initial begin
        req_re = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stall", 64'(mem_stall), 64'd0);
        check_eq("rst_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_err", 64'(resp_err), 64'd0);
        check_eq("rst_rdata", resp_rdata, 64'd0);
        req_re = 1'b0;
        resetn = 1'b1;

        // 1: SD then LD
        xact("t1_sd", 1'b0, 1'b1, 64'h10, 64'h1122334455667788, 3'b011, 1'b0, 64'd0, 1'b0, 1);
        xact("t1_ld", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011, 1'b1, 64'h1122334455667788, 1'b0, 2);
        // 2: SB RMW, sign and zero extended byte loads
        xact("t2_sb", 1'b0, 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 3'b000, 1'b0, 64'd0, 1'b0, 2);
        xact("t2_ld", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 2);
        xact("t2_lb", 1'b1, 1'b0, 64'h13, 64'd0, 3'b000, 1'b1, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2);
        xact("t2_lbu", 1'b1, 1'b0, 64'h13, 64'd0, 3'b100, 1'b1, 64'h00000000000000AB, 1'b0, 2);
        // 3: misaligned SH faults and leaves the word alone
        xact("t3_sh", 1'b0, 1'b1, 64'h11, 64'h0000_0000_0000_BEEF, 3'b001, 1'b1, 64'd0, 1'b1, 1);
        xact("t3_ld", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 2);
        // 4: range, conflict and func3 faults; last valid word
        xact("t4_lw_lim", 1'b1, 1'b0, 64'h2000, 64'd0, 3'b010, 1'b1, 64'd0, 1'b1, 1);
        xact("t4_ld_ok", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 2);
        xact("t4_lw_hi", 1'b1, 1'b0, 64'h8000000000000000, 64'd0, 3'b010, 1'b1, 64'd0, 1'b1, 1);
        xact("t4_both", 1'b1, 1'b1, 64'h10, 64'd0, 3'b011, 1'b1, 64'd0, 1'b1, 1);
        xact("t4_f3_111", 1'b1, 1'b0, 64'h10, 64'd0, 3'b111, 1'b1, 64'd0, 1'b1, 1);
        xact("t4_swu", 1'b0, 1'b1, 64'h10, 64'd0, 3'b110, 1'b1, 64'd0, 1'b1, 1);
        xact("t4_sd_top", 1'b0, 1'b1, 64'h1FF8, 64'hCAFEF00D12345678, 3'b011, 1'b0, 64'd0, 1'b0, 1);
        xact("t4_ld_top", 1'b1, 1'b0, 64'h1FF8, 64'd0, 3'b011, 1'b1, 64'hCAFEF00D12345678, 1'b0, 2);
        xact("t4_ld_chk", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 2);

        // 5: reset during RD_WAIT of an SW drops the write
        xact("t5_sd", 1'b0, 1'b1, 64'h20, 64'h0123456789ABCDEF, 3'b011, 1'b0, 64'd0, 1'b0, 1);
        xact("t5_ld", 1'b1, 1'b0, 64'h20, 64'd0, 3'b011, 1'b1, 64'h0123456789ABCDEF, 1'b0, 2);
        req_we    = 1'b1;
        req_addr  = 64'h24;
        req_wdata = 64'h0000_0000_8000_0000;
        req_func3 = 3'b010;
        @(negedge clk);
        check_eq("t5_stall_idle", 64'(mem_stall), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        check_eq("t5_stall_rst", 64'(mem_stall), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t5_rst_valid", 64'(resp_valid), 64'd0);
        check_eq("t5_rst_err", 64'(resp_err), 64'd0);
        check_eq("t5_rst_rdata", resp_rdata, 64'd0);
        req_we = 1'b0;
        resetn = 1'b1;
        xact("t5_lw", 1'b1, 1'b0, 64'h24, 64'd0, 3'b010, 1'b1, 64'h0000000001234567, 1'b0, 2);

        // SD coinciding with a reset edge is suppressed
        xact("t5b_sd", 1'b0, 1'b1, 64'h30, 64'hA5A5A5A5A5A5A5A5, 3'b011, 1'b0, 64'd0, 1'b0, 1);
        req_we    = 1'b1;
        req_addr  = 64'h30;
        req_wdata = 64'h5A5A5A5A5A5A5A5A;
        req_func3 = 3'b011;
        resetn    = 1'b0;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        resetn = 1'b1;
        xact("t5b_ld", 1'b1, 1'b0, 64'h30, 64'd0, 3'b011, 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0, 2);

        // 6: back-to-back SW then loads, plus an upper-lane SH
        xact("t6_sw", 1'b0, 1'b1, 64'h20, 64'h00000000DEADBEEF, 3'b010, 1'b0, 64'd0, 1'b0, 2);
        xact("t6_lwu", 1'b1, 1'b0, 64'h20, 64'd0, 3'b110, 1'b1, 64'h00000000DEADBEEF, 1'b0, 2);
        xact("t6_lw", 1'b1, 1'b0, 64'h20, 64'd0, 3'b010, 1'b1, 64'hFFFFFFFFDEADBEEF, 1'b0, 2);
        xact("t6_ld", 1'b1, 1'b0, 64'h20, 64'd0, 3'b011, 1'b1, 64'h01234567DEADBEEF, 1'b0, 2);
        xact("t6_sh", 1'b0, 1'b1, 64'h26, 64'h0000_0000_0000_1234, 3'b001, 1'b0, 64'd0, 1'b0, 2);
        xact("t6_ld2", 1'b1, 1'b0, 64'h20, 64'd0, 3'b011, 1'b1, 64'h12344567DEADBEEF, 1'b0, 2);
        xact("t6_lh", 1'b1, 1'b0, 64'h26, 64'd0, 3'b001, 1'b1, 64'h0000000000001234, 1'b0, 2);
        xact("t6_lhu", 1'b1, 1'b0, 64'h22, 64'd0, 3'b101, 1'b1, 64'h000000000000DEAD, 1'b0, 2);
        xact("t6_lh_neg", 1'b1, 1'b0, 64'h22, 64'd0, 3'b001, 1'b1, 64'hFFFFFFFFFFFFDEAD, 1'b0, 2);
        xact("t6_lb7", 1'b1, 1'b0, 64'h27, 64'd0, 3'b000, 1'b1, 64'h0000000000000012, 1'b0, 2);
        @(negedge clk);
        check_eq("idle_valid", 64'(resp_valid), 64'd0);
        check_eq("idle_stall", 64'(mem_stall), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
